// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU divide unit.
// FSM encoding, datapath width and counter width.
package xc_malu_pkg;

    localparam int XC_XLEN  = 32;
    localparam int XC_CNT_W = $clog2(XC_XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } xc_div_state_e;

endpackage

// File: rtl/xc_div_step.sv
// One restoring division step on the {remainder, dividend} shift pair.
// Purely combinational; chained BITS_PER_CYCLE times by the divider.
module xc_div_step
    import xc_malu_pkg::*;
(
    input  logic [XC_XLEN:0]   rem_i,
    input  logic [XC_XLEN-1:0] dvd_i,
    input  logic [XC_XLEN-1:0] dvs_i,
    output logic [XC_XLEN:0]   rem_o,
    output logic [XC_XLEN-1:0] dvd_o
);

    logic [XC_XLEN+1:0] sh;
    logic [XC_XLEN:0]   sub;
    logic               ge;

    always_comb begin
        sh    = {rem_i, dvd_i[XC_XLEN-1]};
        ge    = sh >= {2'b00, dvs_i};
        sub   = sh[XC_XLEN:0] - {1'b0, dvs_i};
        rem_o = ge ? sub : sh[XC_XLEN:0];
        dvd_o = {dvd_i[XC_XLEN-2:0], ge};
    end

endmodule

// File: rtl/xc_malu_div.sv
// Iterative restoring divide/remainder unit for DIV/DIVU/REM/REMU.
// Fixed latency of 32/BITS_PER_CYCLE + 1 cycles from request to ready.
module xc_malu_div
    import xc_malu_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [XC_XLEN-1:0]  rs1,
    input  logic [XC_XLEN-1:0]  rs2,
    input  logic                valid,
    input  logic                flush,
    input  logic                insn_rem,
    input  logic                op_signed,
    output logic                ready,
    output logic [XC_XLEN-1:0]  result_0,
    output logic [XC_XLEN-1:0]  result_1
);

    localparam int BPC = BITS_PER_CYCLE;
    localparam logic [XC_CNT_W-1:0] CNT_LOAD = XC_CNT_W'(XC_XLEN / BPC);
    localparam logic [XC_CNT_W-1:0] CNT_ONE  = XC_CNT_W'(1);

    if (BPC != 1 && BPC != 2 && BPC != 4) begin : g_bpc_bad
        $error("xc_malu_div: BITS_PER_CYCLE must be 1, 2 or 4");
    end

    xc_div_state_e        state_q, state_d;
    logic [XC_CNT_W-1:0]  cnt_q, cnt_d;
    logic [XC_XLEN:0]     rem_q, rem_d;
    logic [XC_XLEN-1:0]   dvd_q, dvd_d;
    logic [XC_XLEN-1:0]   dvs_q, dvs_d;
    logic                 qs_q, qs_d;
    logic                 rs_q, rs_d;
    logic                 dz_q, dz_d;
    logic [XC_XLEN-1:0]   res0_q, res0_d;
    logic [XC_XLEN-1:0]   res1_q, res1_d;

    logic [XC_XLEN:0]     rem_c [0:BPC];
    logic [XC_XLEN-1:0]   dvd_c [0:BPC];

    assign rem_c[0] = rem_q;
    assign dvd_c[0] = dvd_q;

    for (genvar i = 0; i < BPC; i++) begin : g_step
        xc_div_step u_step (
            .rem_i (rem_c[i]),
            .dvd_i (dvd_c[i]),
            .dvs_i (dvs_q),
            .rem_o (rem_c[i+1]),
            .dvd_o (dvd_c[i+1])
        );
    end

    logic [XC_XLEN-1:0] q_mag, r_mag, q_fin, r_fin;
    logic               sgn1, sgn2;

    always_comb begin
        q_mag = dvd_c[BPC];
        r_mag = rem_c[BPC][XC_XLEN-1:0];
        q_fin = (qs_q && !dz_q) ? -q_mag : q_mag;
        r_fin = rs_q ? -r_mag : r_mag;
        sgn1  = op_signed & rs1[XC_XLEN-1];
        sgn2  = op_signed & rs2[XC_XLEN-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        dz_d    = dz_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        case (state_q)
            IDLE: begin
                if (valid && !flush) begin
                    dvd_d   = sgn1 ? -rs1 : rs1;
                    dvs_d   = sgn2 ? -rs2 : rs2;
                    qs_d    = sgn1 ^ sgn2;
                    rs_d    = sgn1;
                    dz_d    = (rs2 == '0);
                    rem_d   = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!valid || flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_c[BPC];
                    dvd_d = dvd_c[BPC];
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        res0_d  = insn_rem ? r_fin : q_fin;
                        res1_d  = insn_rem ? q_fin : r_fin;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || !valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            dz_q    <= 1'b0;
            res0_q  <= '0;
            res1_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            dz_q    <= dz_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
        end
    end

    assign ready    = (state_q == DONE);
    assign result_0 = res0_q;
    assign result_1 = res1_q;

endmodule

// File: doc/xc_malu_div.md
Name: xc_malu_div

Overview:
- Iterative 32-bit integer divide/remainder unit; the responder side of the MALU request handshake (valid/ready/flush, result_1/result_0).
- Sits beside the multiplier datapath in the MALU and serves the DIV/DIVU/REM/REMU instruction variants.
- Uses restoring division, BITS_PER_CYCLE quotient bits per clock.
- Operands are held stable by the requester from valid until flush.

Parameters:
- BITS_PER_CYCLE, 1, quotient bits resolved per iteration cycle. Legal values are 1, 2 and 4; any other value is a $error at elaboration.

Ports:
- clock  input  1  single clock; all state changes on posedge.
- reset  input  1  reset; one clock; reset is synchronous and active-high.
- rs1  input  32  dividend.
- rs2  input  32  divisor.
- valid  input  1  request valid; rs1, rs2, insn_rem and op_signed are stable while high.
- flush  input  1  requester consumed the result (valid && ready); returns unit to IDLE.
- insn_rem  input  1  1 = remainder selected on result_0; 0 = quotient.
- op_signed  input  1  1 = two's-complement operands (DIV/REM); 0 = unsigned.
- ready  output  1  result_0/result_1 valid; high only in DONE.
- result_0  output  32  selected result (quotient, or remainder if insn_rem).
- result_1  output  32  the non-selected result.

Behaviour:
- FSM states: IDLE, CALC, DONE. On reset: state=IDLE, ready=0, result_0=0, result_1=0, iteration counter=0, all datapath registers=0.
- IDLE, valid=1:
  - Latch |rs1| and |rs2| (magnitudes taken only if op_signed).
  - Record quotient sign = rs1[31]^rs2[31], remainder sign = rs1[31] (both 0 if unsigned).
  - Record div_zero = (rs2==0).
  - Clear partial remainder; counter = 32/BPC; next state CALC.
- CALC: each cycle performs BPC restoring steps on the 64-bit {remainder, dividend} shift pair, then decrements the counter.
  - Counter reaching 0 in this cycle: load the sign-corrected results into the result registers; next state DONE.
- Latency: valid seen in IDLE at cycle 0 gives ready=1 at cycle 32/BPC+1. This is 33 cycles for BPC=1, fixed for all operands (no early-out).
- Sign correction:
  - Quotient is negated if its sign bit is set and div_zero=0.
  - Remainder is negated if its sign bit is set.
- Divide by zero (any signedness): quotient=32'hFFFFFFFF, remainder=rs1 unchanged.
- Signed overflow, 32'h80000000 / 32'hFFFFFFFF: quotient=32'h80000000, remainder=0. This falls out of the magnitude path; no special case is required, but it must be verified.
- DONE: ready=1; results held constant.
  - flush=1: next state IDLE, ready=0 next cycle.
  - valid=0 without flush: treated as an abort; next state IDLE.
- Abort: valid=0 during CALC returns to IDLE next cycle, ready never rises, and the result registers keep their previous values.
- flush asserted in IDLE or CALC: returns to IDLE (same as abort).
- New request: a request presented in the same cycle as flush is not accepted. IDLE samples valid on the following cycle, so there is a minimum one idle cycle between operations.
- Reset asserted mid-CALC or in DONE: all state returns to reset values on that edge.
- Widths: partial remainder 33 bits (carry bit for the subtract compare); the magnitude of 32'h80000000 is held as unsigned 32'h80000000.

Decomposition:
- Shared package xc_malu_pkg:
  - FSM state typedef/localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
  - XC_XLEN=32.
  - Counter width derived as $clog2(XC_XLEN+1).
- Sub-module xc_div_step: combinational single restoring iteration (shift, trial subtract, select, quotient bit), instantiated BPC times in a generate chain.

Test Plan:
- Unsigned 100/7 with insn_rem=0 -> result_0=14, result_1=2, ready exactly 33 cycles after valid (BPC=1); flush -> ready=0 next cycle.
- Signed 32'hFFFFFFF9 / 2 with insn_rem=1 -> result_0=32'hFFFFFFFF (-1), result_1=32'hFFFFFFFD (-3).
- Divide by zero, unsigned and signed, 32'h00001234/0 -> quotient 32'hFFFFFFFF, remainder 32'h00001234.
- Signed 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0; the same operands unsigned -> quotient 0, remainder 32'h80000000.
- Abort and recovery:
  - Drop valid at CALC cycle 10 -> ready never asserts; the next request 32'hFFFFFFFF/1 returns quotient 32'hFFFFFFFF, remainder 0.
  - Assert reset mid-CALC -> all outputs 0 on the next cycle, with the same recovery check.
- Randomised back-to-back requests for BPC=1, 2 and 4, checked against a $signed/$unsigned "/" and "%" reference model -> zero mismatches over 10000 cycles.
